// File: rtl/vgahdmi_timing_shifter.sv
// vgahdmi_timing_shifter
// Parametrised video timing generator with a packed-word pixel shifter.
// The X/Y counters produce hsync, vsync, de and frame_start.
// Words are pulled from an upstream FIFO with fetch_next.
// Each word is serialised LSB-first into C_bpp-bit palette indices.
// Optional build macro VGAHDMI_TEST_PICTURE_EN:
//   - adds a test_picture input;
//   - when that input is high, the pixel output becomes an X^Y pattern.
module vgahdmi_timing_shifter #(
  parameter int C_resolution_x      = 640,
  parameter int C_hsync_front_porch = 16,
  parameter int C_hsync_pulse       = 96,
  parameter int C_hsync_back_porch  = 48,
  parameter int C_resolution_y      = 480,
  parameter int C_vsync_front_porch = 10,
  parameter int C_vsync_pulse       = 2,
  parameter int C_vsync_back_porch  = 33,
  parameter int C_hsync_polarity    = 0,
  parameter int C_vsync_polarity    = 0,
  parameter int C_word_bits         = 32,
  parameter int C_bpp               = 8,
  parameter int C_counter_bits      = 12
) (
  input  logic                      clk_pixel,
  input  logic                      reset,
`ifdef VGAHDMI_TEST_PICTURE_EN
  input  logic                      test_picture,
`endif
  input  logic [C_word_bits-1:0]    data_word,
  output logic                      fetch_next,
  output logic [C_bpp-1:0]          pixel,
  output logic                      de,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      frame_start,
  output logic [C_counter_bits-1:0] counter_x,
  output logic [C_counter_bits-1:0] counter_y
);

  localparam int FRAME_X = C_resolution_x + C_hsync_front_porch + C_hsync_pulse + C_hsync_back_porch;
  localparam int FRAME_Y = C_resolution_y + C_vsync_front_porch + C_vsync_pulse + C_vsync_back_porch;
  localparam int PPW     = C_word_bits / C_bpp;

  localparam logic [C_counter_bits-1:0] X_LAST   = C_counter_bits'(FRAME_X - 1);
  localparam logic [C_counter_bits-1:0] Y_LAST   = C_counter_bits'(FRAME_Y - 1);
  localparam logic [C_counter_bits-1:0] RES_X    = C_counter_bits'(C_resolution_x);
  localparam logic [C_counter_bits-1:0] RES_Y    = C_counter_bits'(C_resolution_y);
  localparam logic [C_counter_bits-1:0] HS_START = C_counter_bits'(C_resolution_x + C_hsync_front_porch);
  localparam logic [C_counter_bits-1:0] HS_END   = C_counter_bits'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse);
  localparam logic [C_counter_bits-1:0] VS_START = C_counter_bits'(C_resolution_y + C_vsync_front_porch);
  localparam logic [C_counter_bits-1:0] VS_END   = C_counter_bits'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse);
  localparam logic [C_counter_bits-1:0] ONE      = C_counter_bits'(1);
  // Pixels per word is a power of two, so "X mod ppw" is a simple mask of the low bits.
  localparam logic [C_counter_bits-1:0] PPW_MASK = C_counter_bits'(PPW - 1);
  localparam logic HS_POL = (C_hsync_polarity != 0);
  localparam logic VS_POL = (C_vsync_polarity != 0);

  logic                   fetcharea;
  logic                   word_phase;
  logic [C_word_bits-1:0] shift_reg;
  logic                   hsync_i;
  logic                   vsync_i;

  // Raster position: X runs every clock, Y advances at the end of each line.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      counter_x <= '0;
      counter_y <= '0;
    end else if (counter_x == X_LAST) begin
      counter_x <= '0;
      if (counter_y == Y_LAST)
        counter_y <= '0;
      else
        counter_y <= counter_y + ONE;
    end else begin
      counter_x <= counter_x + ONE;
    end
  end

  assign fetcharea  = (counter_x < RES_X) && (counter_y < RES_Y);
  assign word_phase = ((counter_x & PPW_MASK) == '0);
  assign fetch_next = fetcharea && word_phase && !reset;

  // de and frame_start are registered one clock behind the counters, matching the shifter latency.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      de          <= fetcharea;
      frame_start <= (counter_x == '0) && (counter_y == '0);
    end
  end

  // A fetched word is loaded whole, then pixels are shifted out LSB-first with zero fill.
  always_ff @(posedge clk_pixel) begin
    if (reset)
      shift_reg <= '0;
    else if (fetch_next)
      shift_reg <= data_word;
    else
      shift_reg <= shift_reg >> C_bpp;
  end

  // The horizontal pulse is set and cleared at fixed X positions on every line.
  always_ff @(posedge clk_pixel) begin
    if (reset)
      hsync_i <= 1'b0;
    else if (counter_x == HS_START)
      hsync_i <= 1'b1;
    else if (counter_x == HS_END)
      hsync_i <= 1'b0;
  end

  // The vertical pulse looks only at Y, so its edges fall at the start of lines.
  always_ff @(posedge clk_pixel) begin
    if (reset)
      vsync_i <= 1'b0;
    else if (counter_y == VS_START)
      vsync_i <= 1'b1;
    else if (counter_y == VS_END)
      vsync_i <= 1'b0;
  end

  assign hsync = hsync_i ~^ HS_POL;
  assign vsync = vsync_i ~^ VS_POL;

`ifdef VGAHDMI_TEST_PICTURE_EN
  logic [7:0]       pat_x;
  logic [7:0]       pat_y;
  logic [7:0]       pat_xy;
  logic [C_bpp-1:0] pattern_q;

  assign pat_x  = 8'(counter_x);
  assign pat_y  = 8'(counter_y);
  assign pat_xy = pat_x ^ pat_y;

  // The test pattern is registered so that it lines up with de, just like shifter output.
  always_ff @(posedge clk_pixel) begin
    if (reset)
      pattern_q <= '0;
    else
      pattern_q <= pat_xy[C_bpp-1:0];
  end

  // Output pixel selection: blank outside the active area; otherwise pattern or shifted data.
  always_comb begin
    pixel = '0;
    if (de)
      pixel = test_picture ? pattern_q : shift_reg[C_bpp-1:0];
  end
`else
  // Output pixel selection: blank outside the active area.
  always_comb begin
    pixel = '0;
    if (de)
      pixel = shift_reg[C_bpp-1:0];
  end
`endif

endmodule

// File: tb/tb_vgahdmi_timing_shifter.sv
// tb_vgahdmi_timing_shifter
// Directed bench for vgahdmi_timing_shifter, using two instances.
//   dut_a: 8x4 active area in a 16x8 frame, 16-bit words, 4 bpp.
//   dut_b: 16x2 active area in a 22x5 frame, 8-bit words, 1 bpp.
// With VGAHDMI_TEST_PICTURE_EN defined, a test-picture frame is also run on dut_a.
module tb_vgahdmi_timing_shifter;

  logic clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  logic        reset;
  logic        test_picture;
  logic [15:0] data_word_a;
  logic        fetch_next_a, de_a, hsync_a, vsync_a, frame_start_a;
  logic [3:0]  pixel_a;
  logic [11:0] counter_x_a, counter_y_a;

  logic [7:0]  data_word_b;
  logic        fetch_next_b, de_b, hsync_b, vsync_b, frame_start_b;
  logic [0:0]  pixel_b;
  logic [11:0] counter_x_b, counter_y_b;

  int   total = 0;
  int   bad = 0;
  int   cyc_a;
  int   strobes_a;
  int   starts_a;
  logic tp_mode;

  vgahdmi_timing_shifter #(
    .C_resolution_x(8), .C_hsync_front_porch(2), .C_hsync_pulse(3), .C_hsync_back_porch(3),
    .C_resolution_y(4), .C_vsync_front_porch(1), .C_vsync_pulse(1), .C_vsync_back_porch(2),
    .C_hsync_polarity(0), .C_vsync_polarity(0),
    .C_word_bits(16), .C_bpp(4), .C_counter_bits(12)
  ) dut_a (
    .clk_pixel(clk_pixel), .reset(reset),
`ifdef VGAHDMI_TEST_PICTURE_EN
    .test_picture(test_picture),
`endif
    .data_word(data_word_a), .fetch_next(fetch_next_a), .pixel(pixel_a), .de(de_a),
    .hsync(hsync_a), .vsync(vsync_a), .frame_start(frame_start_a),
    .counter_x(counter_x_a), .counter_y(counter_y_a)
  );

  vgahdmi_timing_shifter #(
    .C_resolution_x(16), .C_hsync_front_porch(2), .C_hsync_pulse(2), .C_hsync_back_porch(2),
    .C_resolution_y(2), .C_vsync_front_porch(1), .C_vsync_pulse(1), .C_vsync_back_porch(1),
    .C_hsync_polarity(0), .C_vsync_polarity(0),
    .C_word_bits(8), .C_bpp(1), .C_counter_bits(12)
  ) dut_b (
    .clk_pixel(clk_pixel), .reset(reset),
`ifdef VGAHDMI_TEST_PICTURE_EN
    .test_picture(1'b0),
`endif
    .data_word(data_word_b), .fetch_next(fetch_next_b), .pixel(pixel_b), .de(de_b),
    .hsync(hsync_b), .vsync(vsync_b), .frame_start(frame_start_b),
    .counter_x(counter_x_b), .counter_y(counter_y_b)
  );

  // One comparison: counts it, and reports tag/observed/expected on mismatch.
  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  // Run dut_a for n clocks, comparing every output against the hand-derived 16x8 frame model.
  task automatic apply_stimulus_a(input int n);
    for (int i = 0; i < n; i++) begin
      int x, y;
      logic fetch_e, de_e;
      logic [3:0] pix_e;
      x = cyc_a % 16;
      y = (cyc_a / 16) % 8;
      data_word_a = (x == 0) ? 16'h4321 : (x == 4) ? 16'h8765 : 16'hBEEF;
      #1;
      fetch_e = (y < 4) && (x < 8) && (x % 4 == 0);
      de_e    = (y < 4) && (x >= 1) && (x <= 8);
      pix_e   = !de_e ? 4'h0 : tp_mode ? 4'((x - 1) ^ y) : 4'(x);
      check_output($sformatf("a_cx x%0d y%0d", x, y), 32'(counter_x_a), 32'(x));
      check_output($sformatf("a_cy x%0d y%0d", x, y), 32'(counter_y_a), 32'(y));
      check_output($sformatf("a_fetch x%0d y%0d", x, y), 32'(fetch_next_a), 32'(fetch_e));
      check_output($sformatf("a_de x%0d y%0d", x, y), 32'(de_a), 32'(de_e));
      check_output($sformatf("a_pixel x%0d y%0d", x, y), 32'(pixel_a), 32'(pix_e));
      check_output($sformatf("a_hsync x%0d y%0d", x, y), 32'(hsync_a), 32'(!(x >= 11 && x <= 13)));
      check_output($sformatf("a_vsync x%0d y%0d", x, y), 32'(vsync_a),
                   32'(!((y == 5 && x >= 1) || (y == 6 && x == 0))));
      check_output($sformatf("a_fstart x%0d y%0d", x, y), 32'(frame_start_a), 32'(x == 1 && y == 0));
      if (fetch_next_a === 1'b1) strobes_a++;
      if (frame_start_a === 1'b1) starts_a++;
      if (cyc_a % 128 == 127) begin
        check_output("a_strobes_per_frame", 32'(strobes_a), 32'd8);
        check_output("a_frame_starts_per_128", 32'(starts_a), 32'd1);
        strobes_a = 0;
        starts_a  = 0;
      end
      tick();
      cyc_a++;
    end
  endtask

  // Run dut_b for one 22x5 frame with 1-bpp words A5 and 3C.
  task automatic apply_stimulus_b();
    int strobes_b;
    strobes_b = 0;
    for (int c = 0; c < 110; c++) begin
      int x, y, idx;
      logic [7:0] w;
      logic fetch_e, de_e, pix_e;
      x = c % 22;
      y = c / 22;
      data_word_b = (x == 0) ? 8'hA5 : (x == 8) ? 8'h3C : 8'hFF;
      #1;
      fetch_e = (y < 2) && (x < 16) && (x % 8 == 0);
      de_e    = (y < 2) && (x >= 1) && (x <= 16);
      idx     = (x >= 1) ? x - 1 : 0;
      w       = (idx < 8) ? 8'hA5 : 8'h3C;
      pix_e   = de_e ? w[idx % 8] : 1'b0;
      check_output($sformatf("b_cx x%0d y%0d", x, y), 32'(counter_x_b), 32'(x));
      check_output($sformatf("b_cy x%0d y%0d", x, y), 32'(counter_y_b), 32'(y));
      check_output($sformatf("b_fetch x%0d y%0d", x, y), 32'(fetch_next_b), 32'(fetch_e));
      check_output($sformatf("b_de x%0d y%0d", x, y), 32'(de_b), 32'(de_e));
      check_output($sformatf("b_pixel x%0d y%0d", x, y), 32'(pixel_b), 32'(pix_e));
      check_output($sformatf("b_hsync x%0d y%0d", x, y), 32'(hsync_b), 32'(!(x == 19 || x == 20)));
      check_output($sformatf("b_vsync x%0d y%0d", x, y), 32'(vsync_b),
                   32'(!((y == 3 && x >= 1) || (y == 4 && x == 0))));
      check_output($sformatf("b_fstart x%0d y%0d", x, y), 32'(frame_start_b), 32'(x == 1 && y == 0));
      if (fetch_next_b === 1'b1) strobes_b++;
      tick();
    end
    check_output("b_strobes_per_frame", 32'(strobes_b), 32'd4);
  endtask

  // Reset the bench-side model of dut_a to the first cycle after reset release.
  task automatic restart_a();
    cyc_a     = 0;
    strobes_a = 0;
    starts_a  = 0;
  endtask

  // Directed sequence: reset, two frames, mid-frame reset, two more frames, 1-bpp instance, optional test picture.
  initial begin
    reset        = 1'b1;
    test_picture = 1'b0;
    tp_mode      = 1'b0;
    data_word_a  = '0;
    data_word_b  = '0;
    restart_a();

    repeat (3) tick();
    check_output("rst_fetch", 32'(fetch_next_a), 32'd0);
    check_output("rst_de", 32'(de_a), 32'd0);
    check_output("rst_pixel", 32'(pixel_a), 32'd0);
    check_output("rst_hsync", 32'(hsync_a), 32'd1);
    check_output("rst_vsync", 32'(vsync_a), 32'd1);
    check_output("rst_fstart", 32'(frame_start_a), 32'd0);
    check_output("rst_cx", 32'(counter_x_a), 32'd0);
    check_output("rst_cy", 32'(counter_y_a), 32'd0);

    reset = 1'b0;
    apply_stimulus_a(293);

    // Abort the third frame at X=5, Y=2.
    check_output("pre_abort_cx", 32'(counter_x_a), 32'd5);
    check_output("pre_abort_cy", 32'(counter_y_a), 32'd2);
    reset = 1'b1;
    #1;
    check_output("abort_fetch_comb", 32'(fetch_next_a), 32'd0);
    tick();
    check_output("abort_de", 32'(de_a), 32'd0);
    check_output("abort_pixel", 32'(pixel_a), 32'd0);
    check_output("abort_hsync", 32'(hsync_a), 32'd1);
    check_output("abort_vsync", 32'(vsync_a), 32'd1);
    check_output("abort_cx", 32'(counter_x_a), 32'd0);
    check_output("abort_cy", 32'(counter_y_a), 32'd0);
    reset = 1'b0;
    restart_a();
    apply_stimulus_a(256);

    // 1-bpp instance, starting from a fresh reset.
    reset = 1'b1;
    repeat (2) tick();
    check_output("b_rst_fetch", 32'(fetch_next_b), 32'd0);
    check_output("b_rst_de", 32'(de_b), 32'd0);
    check_output("b_rst_pixel", 32'(pixel_b), 32'd0);
    reset = 1'b0;
    apply_stimulus_b();

`ifdef VGAHDMI_TEST_PICTURE_EN
    // Test-picture frame: pixel follows X^Y of the previous clock, and fetch_next keeps its pattern.
    test_picture = 1'b1;
    tp_mode      = 1'b1;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
    restart_a();
    apply_stimulus_a(128);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vgahdmi_timing_shifter.md
Name: vgahdmi_timing_shifter

Overview:
- Parametrised successor to the fixed 640x480 VGA/HDMI front end.
- Generates video timing from parameters: resolution, porches, sync widths and sync polarity.
- Pulls packed pixel words from an upstream FIFO via a fetch_next strobe and serialises them into indexed pixels of 1/2/4/8 bits.
- Output drives a palette and the TMDS encoders downstream; no vendor primitives.

Parameters:
- C_resolution_x, 640, active pixels per line; must be a multiple of C_word_bits/C_bpp
- C_hsync_front_porch, 16, pixel clocks
- C_hsync_pulse, 96, pixel clocks
- C_hsync_back_porch, 48, pixel clocks
- C_resolution_y, 480, active lines
- C_vsync_front_porch, 10, lines
- C_vsync_pulse, 2, lines
- C_vsync_back_porch, 33, lines
- C_hsync_polarity, 0, 1 = active-high hsync, 0 = active-low
- C_vsync_polarity, 0, 1 = active-high vsync, 0 = active-low
- C_word_bits, 32, width of fetched data word
- C_bpp, 8, bits per pixel; legal values 1, 2, 4, 8
- C_counter_bits, 12, width of X/Y counters; must hold frame_x-1 and frame_y-1

Ports:
- clk_pixel  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- data_word  in  C_word_bits  next pixel word from FIFO; valid whenever fetch_next is high
- fetch_next  out  1  word consumed this cycle; FIFO advances
- pixel  out  C_bpp  current pixel index; 0 outside the active area
- de  out  1  data enable, aligned with pixel
- hsync  out  1  horizontal sync, polarity per C_hsync_polarity
- vsync  out  1  vertical sync, polarity per C_vsync_polarity
- frame_start  out  1  one-clock pulse at X=0, Y=0; used to flush and resync the FIFO
- counter_x  out  C_counter_bits  current X
- counter_y  out  C_counter_bits  current Y

Behaviour:
- Derived constants: frame_x = res_x+hfp+hpulse+hbp; frame_y likewise; ppw = C_word_bits/C_bpp.
- X counter: increments every clock; wraps frame_x-1 -> 0.
- Y counter: increments when X==frame_x-1; wraps frame_y-1 -> 0.
- fetcharea (combinational) = X<res_x && Y<res_y.
- de is fetcharea registered, so de lags fetcharea by 1 clock.
- fetch_next (combinational) = fetcharea && (X mod ppw == 0) && !reset.
  - Exactly res_x/ppw strobes per active line; none in blanking.
- Shifter:
  - On a fetch_next cycle: load data_word.
  - Otherwise: shift right by C_bpp, zero fill.
  - pixel = de ? shift[C_bpp-1:0] : 0.
  - Pixels leave LSB-first, with 1 clock latency from the fetch_next cycle.
- Sync (internal active-high, registered):
  - hsync_i set when X==res_x+hfp; cleared when X==res_x+hfp+hpulse.
  - vsync_i set when Y==res_y+vfp; cleared when Y==res_y+vfp+vpulse. vsync_i is updated on every clock but compares Y only, so it toggles on line boundaries.
  - Output = hsync_i XNOR C_hsync_polarity (vsync likewise).
- frame_start is registered: high for exactly the one cycle after X==0 && Y==0, i.e. aligned with de of the first pixel.
- Reset:
  - X=Y=0; shift register=0; de=0; pixel=0; hsync_i=vsync_i=0, so outputs sit at their inactive level; frame_start=0; fetch_next=0.
  - Reset mid-line aborts the frame.
  - The first cycle after reset release is X=0, Y=0 and raises fetch_next.
- No backpressure: an FIFO underrun is not detected and stale data_word is displayed.

Optional Feature:
- Macro: VGAHDMI_TEST_PICTURE_EN.
- Defined: adds input test_picture (1 bit).
  - When high, pixel = (counter_x[7:0] ^ counter_y[7:0]) truncated to C_bpp bits, registered to align with de; 0 when de=0.
  - fetch_next is still generated, so the FIFO keeps draining.
- Undefined: no test_picture port and no pattern logic.

Test Plan:
Bench config for tests 1–4: res 8x4, hfp=2, hpulse=3, hbp=3, vfp=1, vpulse=1, vbp=2 (frame 16x8), word=16, bpp=4.
1. Reset held 3 clocks, then released -> fetch_next=1 at X=0 and X=4 of lines 0–3 only; 8 strobes per frame; de high for X=1..8 (registered) on lines 0–3.
2. data_word=16'h4321 at X=0, 16'h8765 at X=4 -> pixel sequence 1,2,3,4,5,6,7,8 on the de cycles; pixel=0 when de=0.
3. Default polarity 0 -> hsync low for exactly 3 clocks, starting the cycle after X==10, every line; vsync low for 16 clocks starting after Y becomes 5.
4. Assert reset at frame 2, X=5, Y=2 -> next cycle de=0, pixel=0, hsync=vsync=1; after release, frame_start is seen exactly once per 128 clocks.
5. bpp=1, word=8, res 16x2, data_word=8'hA5 -> pixels 1,0,1,0,0,1,0,1 (LSB-first); fetch_next every 8th clock of the active area.
6. With VGAHDMI_TEST_PICTURE_EN defined and test_picture=1, at X=3, Y=1 -> pixel=4'h2 on the following clock; fetch_next pattern unchanged from test 1.
